// File: rtl/ifetch_pkg.sv
// Shared types for the instruction fetch unit: FSM encoding, PC step and buffer entry layout.
package ifetch_pkg;

  localparam int unsigned IFU_ADDR_W = 16;
  localparam int unsigned IFU_DATA_W = 32;
  localparam int unsigned PC_INC     = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } ifu_state_t;

  typedef struct packed {
    logic [IFU_ADDR_W-1:0] pc;
    logic [IFU_DATA_W-1:0] inst;
  } ifu_entry_t;

  localparam int unsigned ENTRY_W = $bits(ifu_entry_t);

endpackage

// File: rtl/ifetch_buf.sv
// Instruction buffer: DEPTH-entry synchronous FIFO with flush, push, pop and occupancy count.
// Flush has priority over push and pop; the caller never pushes into a full buffer.
module ifetch_buf #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 48,
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [W-1:0]     i_data,
  output logic [W-1:0]     o_data,
  output logic [CNT_W-1:0] o_count,
  output logic             o_empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= PTR_W'(r_wr_ptr + 1'b1);
      end
      if (i_pop) r_rd_ptr <= PTR_W'(r_rd_ptr + 1'b1);
      case ({i_push, i_pop})
        2'b10:   r_count <= CNT_W'(r_count + 1'b1);
        2'b01:   r_count <= CNT_W'(r_count - 1'b1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/ifetch_unit.sv
// Instruction fetch front end: owns the PC, issues single-word cache reads and queues results for decode.
// Optional IFU_ALIGN_CHECK_EN: misaligned redirects raise fetch_fault and stall fetch instead of being rounded down.
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter int unsigned       ADDR_W    = IFU_ADDR_W,
  parameter int unsigned       DATA_W    = IFU_DATA_W,
  parameter int unsigned       BUF_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC  = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ic_rd,
  output logic [ADDR_W-1:0] ic_address,
  input  logic [DATA_W-1:0] ic_data,
  input  logic              ic_data_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              inst_valid,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  input  logic              inst_ready,
  output logic              fetch_fault
);

  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

  ifu_state_t        r_state;
  ifu_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic              r_ic_rd;
  logic              w_ic_rd_nxt;
  logic [ADDR_W-1:0] r_ic_address;
  logic [ADDR_W-1:0] w_ic_address_nxt;

  logic              w_push;
  logic              w_pop;
  logic              w_empty;
  logic              w_can_issue;
  logic              w_issue_blocked;
  logic [CNT_W-1:0]  w_count;
  logic [ADDR_W-1:0] w_redirect_pc;
  ifu_entry_t        w_push_entry;
  ifu_entry_t        w_head;

`ifdef IFU_ALIGN_CHECK_EN
  logic r_fault;
  logic w_fault_nxt;
  logic w_misaligned;

  assign w_misaligned    = (redirect_pc[1:0] != 2'b00);
  assign w_redirect_pc   = redirect_pc;
  assign w_issue_blocked = r_fault;
  assign fetch_fault     = r_fault;
`else
  assign w_redirect_pc   = redirect_pc & ~ADDR_W'(2'b11);
  assign w_issue_blocked = 1'b0;
  assign fetch_fault     = 1'b0;
`endif

  // Redirect flushes the buffer, so a pop in the same cycle is meaningless.
  assign w_pop       = !w_empty && inst_ready && !redirect_valid;
  assign w_can_issue = (CNT_W'(w_count - CNT_W'(w_pop)) < CNT_W'(BUF_DEPTH));

  assign w_push_entry = '{pc: IFU_ADDR_W'(r_pc), inst: IFU_DATA_W'(ic_data)};

  ifetch_buf #(
    .DEPTH (BUF_DEPTH),
    .W     (ENTRY_W)
  ) u_buf (
    .clk     (clk),
    .rst     (rst),
    .i_flush (redirect_valid),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_push_entry),
    .o_data  (w_head),
    .o_count (w_count),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_ic_rd      <= 1'b0;
      r_ic_address <= '0;
`ifdef IFU_ALIGN_CHECK_EN
      r_fault      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_ic_rd      <= w_ic_rd_nxt;
      r_ic_address <= w_ic_address_nxt;
`ifdef IFU_ALIGN_CHECK_EN
      r_fault      <= w_fault_nxt;
`endif
    end
  end

  // Request stays frozen in REQ/DROP until the cache completes; redirect overrides the PC last.
  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_ic_rd_nxt      = r_ic_rd;
    w_ic_address_nxt = r_ic_address;
    w_push           = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    w_fault_nxt      = r_fault;
`endif
    case (r_state)
      IDLE: begin
        if (!redirect_valid && w_can_issue && !w_issue_blocked) begin
          w_ic_rd_nxt      = 1'b1;
          w_ic_address_nxt = r_pc;
          w_state_nxt      = REQ;
        end
      end
      REQ: begin
        if (ic_data_ready) begin
          w_ic_rd_nxt = 1'b0;
          w_state_nxt = IDLE;
          if (!redirect_valid) begin
            w_push   = 1'b1;
            w_pc_nxt = ADDR_W'(r_pc + ADDR_W'(PC_INC));
          end
        end else if (redirect_valid) begin
          w_state_nxt = DROP;
        end
      end
      DROP: begin
        if (ic_data_ready) begin
          w_ic_rd_nxt = 1'b0;
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_ic_rd_nxt = 1'b0;
        w_state_nxt = IDLE;
      end
    endcase
    if (redirect_valid) begin
      w_pc_nxt = w_redirect_pc;
`ifdef IFU_ALIGN_CHECK_EN
      w_fault_nxt = w_misaligned;
`endif
    end
  end

  assign ic_rd      = r_ic_rd;
  assign ic_address = r_ic_address;
  assign inst_valid = !w_empty;
  assign inst       = DATA_W'(w_head.inst);
  assign inst_pc    = ADDR_W'(w_head.pc);

endmodule

// File: tb/tb_ifetch_unit.sv
// Directed bench for ifetch_unit with a behavioural cache of programmable latency.
// Memory word at address A is {16'hC0DE, A}.
module tb_ifetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ic_rd;
  logic [15:0] ic_address;
  logic [31:0] ic_data;
  logic        ic_data_ready;
  logic        redirect_valid;
  logic [15:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [15:0] inst_pc;
  logic        inst_ready;
  logic        fetch_fault;

  int n_checks = 0;
  int n_errors = 0;
  int cache_lat = 1;
  int wait_cnt  = 0;

  ifetch_unit dut (
    .clk            (clk),
    .rst            (rst),
    .ic_rd          (ic_rd),
    .ic_address     (ic_address),
    .ic_data        (ic_data),
    .ic_data_ready  (ic_data_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc),
    .inst_ready     (inst_ready),
    .fetch_fault    (fetch_fault)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then park the PC at pc via a redirect in IDLE; the next tick issues pc.
  task automatic start_at(input logic [15:0] pc);
    rst            = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst            = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  // Cache model: respond cache_lat negedges after seeing ic_rd, one-cycle ready pulse.
  initial begin
    ic_data_ready = 1'b0;
    ic_data       = '0;
    forever begin
      @(negedge clk);
      if (rst || !ic_rd || ic_data_ready) begin
        ic_data_ready = 1'b0;
        wait_cnt      = 0;
      end else begin
        wait_cnt++;
        if (wait_cnt >= cache_lat) begin
          ic_data_ready = 1'b1;
          ic_data       = {16'hC0DE, ic_address};
          wait_cnt      = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst            = 1'b1;
    inst_ready     = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    check_eq("rst_ic_rd",   32'(ic_rd), 32'd0);
    check_eq("rst_ic_addr", 32'(ic_address), 32'd0);
    check_eq("rst_valid",   32'(inst_valid), 32'd0);
    check_eq("rst_inst",    inst, 32'd0);
    check_eq("rst_inst_pc", 32'(inst_pc), 32'd0);
    check_eq("rst_fault",   32'(fetch_fault), 32'd0);

    // 1: warm cache streaming from RESET_PC
    rst = 1'b0;
    cache_lat = 1;
    tick();
    check_eq("t1_rd0",    32'(ic_rd), 32'd1);
    check_eq("t1_addr0",  32'(ic_address), 32'h0000);
    tick();
    check_eq("t1_valid0", 32'(inst_valid), 32'd1);
    check_eq("t1_pc0",    32'(inst_pc), 32'h0000);
    check_eq("t1_inst0",  inst, 32'hC0DE0000);
    check_eq("t1_rd_gap", 32'(ic_rd), 32'd0);
    tick();
    check_eq("t1_addr4",  32'(ic_address), 32'h0004);
    check_eq("t1_rd4",    32'(ic_rd), 32'd1);
    check_eq("t1_popped", 32'(inst_valid), 32'd0);
    tick();
    check_eq("t1_pc4",    32'(inst_pc), 32'h0004);
    check_eq("t1_inst4",  inst, 32'hC0DE0004);
    tick();
    check_eq("t1_addr8",  32'(ic_address), 32'h0008);
    tick();
    check_eq("t1_pc8",    32'(inst_pc), 32'h0008);

    // 2: cold miss at 0x0010
    start_at(16'h0010);
    cache_lat = 2;
    tick();
    check_eq("t2_rd_a",    32'(ic_rd), 32'd1);
    check_eq("t2_addr_a",  32'(ic_address), 32'h0010);
    tick();
    check_eq("t2_rd_b",    32'(ic_rd), 32'd1);
    check_eq("t2_addr_b",  32'(ic_address), 32'h0010);
    check_eq("t2_nvalid",  32'(inst_valid), 32'd0);
    tick();
    check_eq("t2_valid",   32'(inst_valid), 32'd1);
    check_eq("t2_pc",      32'(inst_pc), 32'h0010);
    tick();
    check_eq("t2_one_push", 32'(inst_valid), 32'd0);
    check_eq("t2_next",     32'(ic_address), 32'h0014);

    // 3: backpressure fills BUF_DEPTH entries then stalls
    inst_ready = 1'b0;
    start_at(16'h0000);
    cache_lat = 1;
    repeat (4) tick();
    tick();
    check_eq("t3_stall_a", 32'(ic_rd), 32'd0);
    tick();
    check_eq("t3_stall_b", 32'(ic_rd), 32'd0);
    check_eq("t3_head0",   32'(inst_pc), 32'h0000);
    inst_ready = 1'b1;
    tick();
    check_eq("t3_head4",   32'(inst_pc), 32'h0004);
    check_eq("t3_resume",  32'(ic_rd), 32'd1);
    check_eq("t3_addr8",   32'(ic_address), 32'h0008);
    tick();
    check_eq("t3_head8",   32'(inst_pc), 32'h0008);
    check_eq("t3_inst8",   inst, 32'hC0DE0008);

    // 4: redirect to 0x0100 during a miss on 0x0020
    start_at(16'h0020);
    cache_lat = 3;
    tick();
    check_eq("t4_issue",  32'(ic_address), 32'h0020);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0100;
    tick();
    redirect_valid = 1'b0;
    check_eq("t4_hold_rd_a", 32'(ic_rd), 32'd1);
    check_eq("t4_hold_ad_a", 32'(ic_address), 32'h0020);
    tick();
    check_eq("t4_hold_ad_b", 32'(ic_address), 32'h0020);
    tick();
    cache_lat = 1;
    check_eq("t4_drop_rd",   32'(ic_rd), 32'd0);
    check_eq("t4_dropped",   32'(inst_valid), 32'd0);
    tick();
    check_eq("t4_new_issue", 32'(ic_address), 32'h0100);
    check_eq("t4_no_stale",  32'(inst_valid), 32'd0);
    tick();
    check_eq("t4_new_pc",    32'(inst_pc), 32'h0100);

    // 5: redirect coinciding with data_ready and a pop
    inst_ready = 1'b0;
    start_at(16'h0000);
    tick();
    tick();
    tick();
    check_eq("t5_pending", 32'(ic_address), 32'h0004);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0300;
    inst_ready     = 1'b1;
    tick();
    redirect_valid = 1'b0;
    check_eq("t5_flushed", 32'(inst_valid), 32'd0);
    check_eq("t5_rd_low",  32'(ic_rd), 32'd0);
    tick();
    check_eq("t5_issue",   32'(ic_address), 32'h0300);
    check_eq("t5_empty",   32'(inst_valid), 32'd0);
    tick();
    check_eq("t5_pc",      32'(inst_pc), 32'h0300);

    // PC wraps modulo 2^16
    start_at(16'hFFFC);
    tick();
    check_eq("wrap_issue", 32'(ic_address), 32'hFFFC);
    tick();
    check_eq("wrap_pc",    32'(inst_pc), 32'hFFFC);
    tick();
    check_eq("wrap_next",  32'(ic_address), 32'h0000);

    // 6: misaligned redirect
    start_at(16'h0102);
`ifdef IFU_ALIGN_CHECK_EN
    check_eq("t6_fault",    32'(fetch_fault), 32'd1);
    tick();
    check_eq("t6_stop_a",   32'(ic_rd), 32'd0);
    tick();
    check_eq("t6_stop_b",   32'(ic_rd), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0200;
    tick();
    redirect_valid = 1'b0;
    check_eq("t6_clear",    32'(fetch_fault), 32'd0);
    tick();
    check_eq("t6_rd",       32'(ic_rd), 32'd1);
    check_eq("t6_addr",     32'(ic_address), 32'h0200);
`else
    tick();
    check_eq("t6_nofault",  32'(fetch_fault), 32'd0);
    check_eq("t6_rd",       32'(ic_rd), 32'd1);
    check_eq("t6_aligned",  32'(ic_address), 32'h0100);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
